pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: number of consecutive stable synchronized samples that qualify a start press.
REQ-002 Parameter FLUSH_CYCLES, default 2: number of bubble cycles inserted after a taken branch or jump.
REQ-003 Parameter DRAIN_CYCLES, default 3: number of cycles the pipeline drains after a halt is decoded.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high; the ports are named clk and rst.
REQ-005 clk  input  1  core clock.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 start_button  input  1  raw, asynchronous push-button level.
REQ-008 halt_ID  input  1  halt instruction present in ID.
REQ-009 load_EX  input  1  memory-read (scalar or vector) instruction present in EX.
REQ-010 Rd_EX  input  5  destination register in EX.
REQ-011 Rs1_ID, Rs2_ID  input  5 each  source registers in ID.
REQ-012 branch_taken_EX  input  1  PC redirect resolved in EX.
REQ-013 stall  output  1  freeze the PC and IF/ID, and bubble EX/MEM.
REQ-014 flush  output  1  clear IF/ID and ID/EX.
REQ-015 cpu_run  output  1  program executing.
REQ-016 done  output  1  program finished.
REQ-017 cycle_count  output  32  cycles spent in the non-IDLE, non-DONE states.

Function
REQ-018 The FSM SHALL have the states IDLE, RUN, LOAD_STALL, FLUSH, DRAIN and DONE, registered on clk.
REQ-019 A start press SHALL be defined as a 0->1 transition of the start_button level after a 2-flop synchronizer and a debounce filter of DEBOUNCE_CYCLES stable samples.
REQ-020 IDLE: stall=1, cpu_run=0; a start press SHALL clear cycle_count and move the FSM to RUN on the next edge.
REQ-021 Load-use hazard = load_EX & (Rd_EX!=0) & ((Rd_EX==Rs1_ID) | (Rd_EX==Rs2_ID)), with the 5-bit compare including bit 4 (vector select).
REQ-022 RUN with a hazard: stall SHALL be 1 combinationally in the same cycle and the FSM SHALL enter LOAD_STALL; total stall is 2 cycles.
REQ-023 LOAD_STALL: stall=1 for one cycle, then the FSM SHALL return to RUN.
REQ-024 RUN or LOAD_STALL with branch_taken_EX: flush SHALL be 1 combinationally and the FSM SHALL enter FLUSH; the branch has priority over the hazard and over halt_ID.
REQ-025 FLUSH: flush=1 for FLUSH_CYCLES-1 further cycles, stall=0, then the FSM SHALL go to RUN.
REQ-026 RUN with halt_ID and neither branch nor hazard: the FSM SHALL go to DRAIN.
REQ-027 DRAIN: stall=1 (IF frozen) for DRAIN_CYCLES cycles, then the FSM SHALL go to DONE.
REQ-028 DONE: done=1, cpu_run=0, stall=1, cycle_count frozen; a new start press SHALL move the FSM to RUN and clear cycle_count.
REQ-029 cpu_run SHALL be 1 in RUN, LOAD_STALL, FLUSH and DRAIN.
REQ-030 cycle_count SHALL increment each cycle in which cpu_run=1 and SHALL saturate at 32'hFFFFFFFF (no wrap).
REQ-031 A start press in RUN, LOAD_STALL, FLUSH or DRAIN SHALL be ignored.
REQ-032 halt_ID arriving while in DRAIN SHALL be ignored.
REQ-033 stall and flush SHALL never both be 1; flush wins.

Reset
REQ-034 rst SHALL force, asynchronously: state=IDLE, the synchronizer and debounce counter to 0, cycle_count=0, done=0, cpu_run=0, flush=0, stall=1.
REQ-035 Reset mid-operation (any state) SHALL abort to IDLE with no residual flush or stall pulse count.
REQ-036 After rst deasserts, a start button already held high SHALL NOT count as a press until it is released and pressed again.

Structure
REQ-037 The state enum and the default widths of DEBOUNCE_CYCLES, FLUSH_CYCLES and DRAIN_CYCLES SHALL live in the shared package cpu_pkg.
REQ-038 The synchronizer and debounce filter SHALL be the sub-module start_debouncer (clk, rst, btn_in, press_pulse), producing a one-cycle pulse.
REQ-039 The hazard compare SHALL be combinational inside pipeline_ctrl; no other sub-modules.

Verification
REQ-040 Reset, then start_button held high for 20 cycles -> press pulse 18 cycles after the rise (2 sync + 16 debounce); RUN on the next edge; cycle_count=0.
REQ-041 RUN, load_EX=1, Rd_EX=5, Rs2_ID=5 -> stall=1 for exactly 2 cycles; RUN again. Repeat with Rd_EX=0 -> no stall.
REQ-042 RUN, branch_taken_EX=1 together with a hazard -> flush=1 for 2 cycles, stall=0 throughout.
REQ-043 RUN, halt_ID=1 at cycle_count=100 -> 3 cycles of stall, then done=1 and cycle_count=104, held thereafter.
REQ-044 rst pulsed during FLUSH -> state IDLE, flush=0 immediately (asynchronous), stall=1.
REQ-045 In DONE, start press -> RUN, cycle_count=0, done=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared controller state encoding and default timing parameters
package cpu_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_LOAD_STALL,
    S_FLUSH,
    S_DRAIN,
    S_DONE
  } state_t;
  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_FLUSH_CYCLES = 2;
  localparam int DEF_DRAIN_CYCLES = 3;
endpackage

// File: rtl/start_debouncer.sv
// start_debouncer: synchronizes and debounces the start button into a one-cycle press pulse
module start_debouncer
  import cpu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic press_pulse
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic s1, s2, v1, v2, db, armed, settle;
  logic [CW-1:0] cnt;
  assign settle = (s2 != db) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
  // armed only after a genuine low is seen, so a button held through reset is not a press
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      v1 <= 1'b0;
      v2 <= 1'b0;
      db <= 1'b0;
      armed <= 1'b0;
      cnt <= '0;
      press_pulse <= 1'b0;
    end else begin
      s1 <= btn_in;
      s2 <= s1;
      v1 <= 1'b1;
      v2 <= v1;
      armed <= armed | (v2 & ~s2);
      cnt <= (s2 == db || settle) ? '0 : cnt + CW'(1);
      db <= settle ? s2 : db;
      press_pulse <= settle & s2 & armed;
    end
  end
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: run/hazard/flush/drain sequencing for the CPU pipeline with a run-cycle counter
module pipeline_ctrl
  import cpu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES,
  parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_button,
  input  logic        halt_ID,
  input  logic        load_EX,
  input  logic [4:0]  Rd_EX,
  input  logic [4:0]  Rs1_ID,
  input  logic [4:0]  Rs2_ID,
  input  logic        branch_taken_EX,
  output logic        stall,
  output logic        flush,
  output logic        cpu_run,
  output logic        done,
  output logic [31:0] cycle_count
);
  localparam int CW = $clog2(FLUSH_CYCLES + DRAIN_CYCLES + 1);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic press, hazard, clr;
  start_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .clk(clk),
    .rst(rst),
    .btn_in(start_button),
    .press_pulse(press)
  );
  assign hazard = load_EX && (Rd_EX != 5'd0) && ((Rd_EX == Rs1_ID) || (Rd_EX == Rs2_ID));
  assign cpu_run = state inside {S_RUN, S_LOAD_STALL, S_FLUSH, S_DRAIN};
  assign done = state == S_DONE;
  // branch outranks hazard and halt; stall is only raised on paths where flush stays low
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    stall = 1'b0;
    flush = 1'b0;
    clr = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        stall = 1'b1;
        clr = press;
        state_n = press ? S_RUN : state;
      end
      S_RUN, S_LOAD_STALL: begin
        if (branch_taken_EX) begin
          flush = 1'b1;
          state_n = FLUSH_CYCLES > 1 ? S_FLUSH : S_RUN;
          cnt_n = CW'(FLUSH_CYCLES > 1 ? FLUSH_CYCLES - 2 : 0);
        end else if (state == S_LOAD_STALL) begin
          stall = 1'b1;
          state_n = S_RUN;
        end else if (hazard) begin
          stall = 1'b1;
          state_n = S_LOAD_STALL;
        end else if (halt_ID) begin
          state_n = S_DRAIN;
          cnt_n = CW'(DRAIN_CYCLES > 0 ? DRAIN_CYCLES - 1 : 0);
        end
      end
      S_FLUSH: begin
        flush = 1'b1;
        state_n = cnt == '0 ? S_RUN : S_FLUSH;
        cnt_n = cnt == '0 ? cnt : cnt - CW'(1);
      end
      S_DRAIN: begin
        stall = 1'b1;
        state_n = cnt == '0 ? S_DONE : S_DRAIN;
        cnt_n = cnt == '0 ? cnt : cnt - CW'(1);
      end
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt <= '0;
      cycle_count <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      cycle_count <= clr ? '0 : (cpu_run && ~&cycle_count) ? cycle_count + 32'd1 : cycle_count;
    end
  end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed vectors with a queued scoreboard checked by a negedge monitor
module tb_pipeline_ctrl;
  logic clk = 1'b0, rst, start_button, halt_ID, load_EX, branch_taken_EX;
  logic [4:0] Rd_EX, Rs1_ID, Rs2_ID;
  logic stall, flush, cpu_run, done;
  logic [31:0] cycle_count;
  int passed = 0, total = 0;
  typedef struct {
    string name;
    logic st, fl, run, dn;
    logic [31:0] cc;
  } exp_t;
  exp_t q[$];

  pipeline_ctrl dut (
    .clk(clk), .rst(rst), .start_button(start_button), .halt_ID(halt_ID),
    .load_EX(load_EX), .Rd_EX(Rd_EX), .Rs1_ID(Rs1_ID), .Rs2_ID(Rs2_ID),
    .branch_taken_EX(branch_taken_EX), .stall(stall), .flush(flush),
    .cpu_run(cpu_run), .done(done), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_push(input string n, input logic st, fl, run, dn, input logic [31:0] cc);
    exp_t e;
    e.name = n; e.st = st; e.fl = fl; e.run = run; e.dn = dn; e.cc = cc;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      total++;
      if ({stall, flush, cpu_run, done, cycle_count} === {e.st, e.fl, e.run, e.dn, e.cc})
        passed++;
      else
        $display("FAIL %s: got stall=%b flush=%b run=%b done=%b cc=%0d, want stall=%b flush=%b run=%b done=%b cc=%0d",
                 e.name, stall, flush, cpu_run, done, cycle_count, e.st, e.fl, e.run, e.dn, e.cc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, total);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start_button = 1'b0; halt_ID = 1'b0; load_EX = 1'b0; branch_taken_EX = 1'b0;
    Rd_EX = '0; Rs1_ID = '0; Rs2_ID = '0;
    step; step; exp_push("reset", 1, 0, 0, 0, 0);
    step; rst = 1'b0; exp_push("idle_after_rst", 1, 0, 0, 0, 0);
    repeat (4) step;
    step; start_button = 1'b1;
    for (int i = 1; i <= 18; i++) begin
      step;
      if (i == 18) exp_push("pre_press_idle", 1, 0, 0, 0, 0);
    end
    step; exp_push("run_entry", 0, 0, 1, 0, 0);
    step; load_EX = 1; Rd_EX = 5; Rs2_ID = 5; exp_push("hazard", 1, 0, 1, 0, 1);
    step; exp_push("load_stall", 1, 0, 1, 0, 2);
    step; load_EX = 0; Rd_EX = 0; Rs2_ID = 0; start_button = 1'b0; exp_push("after_stall", 0, 0, 1, 0, 3);
    step; load_EX = 1; exp_push("rd0_no_stall", 0, 0, 1, 0, 4);
    step; Rd_EX = 5'h15; Rs1_ID = 5'h05; exp_push("bit4_differs", 0, 0, 1, 0, 5);
    step; Rs1_ID = 5'h15; exp_push("vec_hazard", 1, 0, 1, 0, 6);
    step; exp_push("vec_load_stall", 1, 0, 1, 0, 7);
    step; load_EX = 0; Rd_EX = 0; Rs1_ID = 0; exp_push("vec_after", 0, 0, 1, 0, 8);
    step; branch_taken_EX = 1; load_EX = 1; Rd_EX = 5; Rs2_ID = 5; halt_ID = 1;
    exp_push("branch_prio", 0, 1, 1, 0, 9);
    step; branch_taken_EX = 0; halt_ID = 0; exp_push("flush2", 0, 1, 1, 0, 10);
    step; load_EX = 0; Rd_EX = 0; Rs2_ID = 0; exp_push("flush_done", 0, 0, 1, 0, 11);
    step; load_EX = 1; Rd_EX = 7; Rs1_ID = 7; exp_push("hazard2", 1, 0, 1, 0, 12);
    step; branch_taken_EX = 1; exp_push("ls_branch", 0, 1, 1, 0, 13);
    step; branch_taken_EX = 0; load_EX = 0; Rd_EX = 0; Rs1_ID = 0; exp_push("ls_flush", 0, 1, 1, 0, 14);
    step; exp_push("ls_flush_done", 0, 0, 1, 0, 15);
    repeat (84) step;
    step; halt_ID = 1; exp_push("halt", 0, 0, 1, 0, 100);
    for (int i = 1; i <= 3; i++) begin
      step; exp_push("drain", 1, 0, 1, 0, 32'(100 + i));
    end
    step; halt_ID = 0; exp_push("done", 1, 0, 0, 1, 104);
    repeat (5) step;
    exp_push("done_hold", 1, 0, 0, 1, 104);
    step; start_button = 1'b1;
    for (int i = 1; i <= 18; i++) begin
      step;
      if (i == 18) exp_push("done_pre_press", 1, 0, 0, 1, 104);
    end
    step; exp_push("restart", 0, 0, 1, 0, 0);
    for (int i = 1; i <= 40; i++) begin
      step;
      if (i == 1) start_button = 1'b0;
      if (i == 20) start_button = 1'b1;
      if (i == 40) exp_push("press_ignored", 0, 0, 1, 0, 40);
    end
    step; branch_taken_EX = 1; exp_push("branch2", 0, 1, 1, 0, 41);
    step; branch_taken_EX = 0; rst = 1'b1; exp_push("rst_in_flush", 1, 0, 0, 0, 0);
    step; exp_push("rst_hold", 1, 0, 0, 0, 0);
    step; rst = 1'b0;
    repeat (30) step;
    exp_push("held_no_press", 1, 0, 0, 0, 0);
    step; start_button = 1'b0;
    repeat (25) step;
    step; start_button = 1'b1;
    for (int i = 1; i <= 18; i++) begin
      step;
      if (i == 18) exp_push("repress_pre", 1, 0, 0, 0, 0);
    end
    step; exp_push("repress", 0, 0, 1, 0, 0);
    step; step;
    if (q.size() != 0) begin
      total++;
      $display("FAIL drain_queue: got %0d pending, want 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
